// File: rtl/mlp_pkg.sv
// Shared types and saturating-arithmetic helpers for the sequential MLP classifier.
// Optional saturation reporting in the engine is enabled with MLP_SAT_FLAG_EN.
package mlp_pkg;

    localparam int DATA_W = 16;
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L1   = 3'd1,
        L2   = 3'd2,
        ARG  = 3'd3,
        DONE = 3'd4
    } state_t;

    function automatic int label_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int LABEL_W = label_w(10);

    // Adds two w-bit signed values (carried in 32 bits) and clamps to the w-bit range.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [32:0] s;
        logic signed [32:0] mx;
        logic signed [32:0] mn;
        s  = 33'(a) + 33'(b);
        mx = (33'sd1 <<< (w - 1)) - 33'sd1;
        mn = -(33'sd1 <<< (w - 1));
        if (s > mx)
            return mx[31:0];
        else if (s < mn)
            return mn[31:0];
        else
            return s[31:0];
    endfunction

    function automatic logic sat_ovf(input logic signed [31:0] a,
                                     input logic signed [31:0] b,
                                     input int w);
        logic signed [32:0] s;
        logic signed [32:0] mx;
        logic signed [32:0] mn;
        s  = 33'(a) + 33'(b);
        mx = (33'sd1 <<< (w - 1)) - 33'sd1;
        mn = -(33'sd1 <<< (w - 1));
        return (s > mx) || (s < mn);
    endfunction

endpackage

// File: rtl/mlp_sat_mac.sv
// One L2 lane: signed product, truncate-toward-zero rescale by 2^FRAC, clamp, saturating add.
// Clamp indications are only present when MLP_SAT_FLAG_EN is defined.
module mlp_sat_mac
    import mlp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic signed [WIDTH-1:0] i_w,
    input  logic signed [WIDTH-1:0] i_h,
    input  logic signed [WIDTH-1:0] i_acc,
`ifdef MLP_SAT_FLAG_EN
    output logic                    o_prod_sat,
    output logic                    o_acc_sat,
`endif
    output logic signed [WIDTH-1:0] o_acc
);

    localparam logic signed [WIDTH-1:0]   S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0]   S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [2*WIDTH-1:0] Q_MAX = (2*WIDTH)'(S_MAX);
    localparam logic signed [2*WIDTH-1:0] Q_MIN = (2*WIDTH)'(S_MIN);

    logic signed [2*WIDTH-1:0] w_p;
    logic signed [2*WIDTH-1:0] w_bias;
    logic signed [2*WIDTH-1:0] w_q;
    logic signed [WIDTH-1:0]   w_qs;
    logic signed [31:0]        w_sum;

    assign w_p = (2*WIDTH)'(i_w) * (2*WIDTH)'(i_h);
    // Biasing negative products before the arithmetic shift makes it round toward zero.
    assign w_bias = w_p[2*WIDTH-1] ? {{(2*WIDTH-FRAC){1'b0}}, {FRAC{1'b1}}} : '0;
    assign w_q    = (w_p + w_bias) >>> FRAC;

    always_comb begin
        w_qs = w_q[WIDTH-1:0];
        if (w_q > Q_MAX)
            w_qs = S_MAX;
        else if (w_q < Q_MIN)
            w_qs = S_MIN;
    end

    assign w_sum = sat_add(32'(i_acc), 32'(w_qs), WIDTH);
    assign o_acc = w_sum[WIDTH-1:0];

`ifdef MLP_SAT_FLAG_EN
    assign o_prod_sat = (w_q > Q_MAX) || (w_q < Q_MIN);
    assign o_acc_sat  = sat_ovf(32'(i_acc), 32'(w_qs), WIDTH);
`endif

endmodule

// File: rtl/mlp_seq_engine.sv
// Sequential binary-input two-layer MLP: chunked L1 accumulate, ReLU, L2 MAC lanes, argmax scan.
// Defining MLP_SAT_FLAG_EN adds out_sat, set when any clamp occurred while processing the frame.
module mlp_seq_engine
    import mlp_pkg::*;
#(
    parameter int N_IN  = 324,
    parameter int N_HID = 10,
    parameter int N_OUT = 10,
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int CHUNK = 18,
    localparam int LBL_W = label_w(N_OUT)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_HID*N_IN*WIDTH-1:0]   w1,
    input  logic [N_OUT*N_HID*WIDTH-1:0]  w2,
    input  logic [N_IN-1:0]               in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LBL_W-1:0]              out_label,
    output logic                          out_last,
`ifdef MLP_SAT_FLAG_EN
    output logic                          out_sat,
`endif
    output logic [2:0]                    dbg_state
);

    localparam int L1_CYC = N_IN / CHUNK;
    localparam int CNT_W  = $clog2(L1_CYC + N_HID + N_OUT);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [N_IN-1:0]         r_data;
    logic                    r_last;
    logic signed [WIDTH-1:0] r_acc1 [N_HID];
    logic signed [WIDTH-1:0] r_h    [N_HID];
    logic signed [WIDTH-1:0] r_acc2 [N_OUT];
    logic signed [WIDTH-1:0] r_best;
    logic [LBL_W-1:0]        r_idx;

    logic signed [WIDTH-1:0] w_acc1_nxt [N_HID];
    logic signed [WIDTH-1:0] w_acc2_nxt [N_OUT];
    logic signed [WIDTH-1:0] w_w2_sel   [N_OUT];
    logic signed [WIDTH-1:0] w_h_sel;
    logic signed [WIDTH-1:0] w_arg_sel;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the source holds data/valid until then, and ready never depends on the same-side valid.
    assign in_ready  = (r_state == IDLE) && !reset;
    assign out_valid = (r_state == DONE);
    assign out_label = r_idx;
    assign out_last  = r_last;
    assign dbg_state = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = L1;
            L1:      if (r_cnt == CNT_W'(L1_CYC - 1)) w_state_nxt = L2;
            L2:      if (r_cnt == CNT_W'(N_HID - 1)) w_state_nxt = ARG;
            ARG:     if (r_cnt == CNT_W'(N_OUT - 1)) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // L1: r_data is shifted down each cycle so the current chunk always sits in the low bits.
    always_comb begin
        logic signed [31:0] v_sum;
        int                 v_base;
        v_sum  = '0;
        v_base = 0;
        for (int i = 0; i < N_HID; i++) begin
            w_acc1_nxt[i] = r_acc1[i];
            for (int b = 0; b < CHUNK; b++) begin
                v_base = (i * N_IN + int'(r_cnt) * CHUNK + b) * WIDTH;
                if (r_data[b]) begin
                    v_sum = sat_add(32'(w_acc1_nxt[i]), 32'($signed(w1[v_base +: WIDTH])), WIDTH);
                    w_acc1_nxt[i] = v_sum[WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        w_h_sel   = r_h[0];
        w_arg_sel = r_acc2[0];
        for (int i = 0; i < N_HID; i++)
            if (r_cnt == CNT_W'(i)) w_h_sel = r_h[i];
        for (int k = 0; k < N_OUT; k++) begin
            if (r_cnt == CNT_W'(k)) w_arg_sel = r_acc2[k];
            w_w2_sel[k] = '0;
            for (int i = 0; i < N_HID; i++)
                if (r_cnt == CNT_W'(i)) w_w2_sel[k] = $signed(w2[(k * N_HID + i) * WIDTH +: WIDTH]);
        end
    end

`ifdef MLP_SAT_FLAG_EN
    logic [N_OUT-1:0] w_prod_sat;
    logic [N_OUT-1:0] w_acc_sat;
    logic             w_l1_sat;
    logic             r_sat;
`endif

    for (genvar k = 0; k < N_OUT; k++) begin : g_mac
        mlp_sat_mac #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC)
        ) u_mac (
            .i_w        (w_w2_sel[k]),
            .i_h        (w_h_sel),
            .i_acc      (r_acc2[k]),
`ifdef MLP_SAT_FLAG_EN
            .o_prod_sat (w_prod_sat[k]),
            .o_acc_sat  (w_acc_sat[k]),
`endif
            .o_acc      (w_acc2_nxt[k])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_data <= '0;
            r_last <= 1'b0;
            r_best <= '0;
            r_idx  <= '0;
            for (int i = 0; i < N_HID; i++) begin
                r_acc1[i] <= '0;
                r_h[i]    <= '0;
            end
            for (int k = 0; k < N_OUT; k++)
                r_acc2[k] <= '0;
        end else begin
            if ((w_state_nxt != r_state) || (r_state == IDLE) || (r_state == DONE))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CNT_W'(1);
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data <= in_data;
                        r_last <= in_last;
                        for (int i = 0; i < N_HID; i++) r_acc1[i] <= '0;
                        for (int k = 0; k < N_OUT; k++) r_acc2[k] <= '0;
                    end
                end
                L1: begin
                    r_data <= r_data >> CHUNK;
                    for (int i = 0; i < N_HID; i++) begin
                        r_acc1[i] <= w_acc1_nxt[i];
                        if (w_state_nxt == L2)
                            r_h[i] <= w_acc1_nxt[i][WIDTH-1] ? '0 : w_acc1_nxt[i];
                    end
                end
                L2: begin
                    for (int k = 0; k < N_OUT; k++) r_acc2[k] <= w_acc2_nxt[k];
                end
                ARG: begin
                    // Strictly-greater replacement keeps the lowest index on ties.
                    if (r_cnt == '0) begin
                        r_best <= r_acc2[0];
                        r_idx  <= '0;
                    end else if (w_arg_sel > r_best) begin
                        r_best <= w_arg_sel;
                        r_idx  <= LBL_W'(r_cnt);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MLP_SAT_FLAG_EN
    always_comb begin
        w_l1_sat = 1'b0;
        for (int i = 0; i < N_HID; i++)
            for (int b = 0; b < CHUNK; b++)
                if (r_data[b] && sat_ovf(32'(r_acc1[i]),
                        32'($signed(w1[(i * N_IN + int'(r_cnt) * CHUNK + b) * WIDTH +: WIDTH])), WIDTH))
                    w_l1_sat = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_sat <= 1'b0;
        else if (r_state == IDLE && in_valid)
            r_sat <= 1'b0;
        else if (r_state == L1)
            r_sat <= r_sat | w_l1_sat;
        else if (r_state == L2)
            r_sat <= r_sat | (|w_prod_sat) | (|w_acc_sat);
    end

    assign out_sat = r_sat;
`endif

endmodule

// File: tb/tb_mlp_seq_engine.sv
// Self-checking bench for mlp_seq_engine: directed cases plus randomized frames scored by a reference model.
module tb_mlp_seq_engine;
    import mlp_pkg::*;

    localparam int N_IN  = 324;
    localparam int N_HID = 10;
    localparam int N_OUT = 10;
    localparam int WIDTH = 16;
    localparam int FRAC  = 8;
    localparam int CHUNK = 18;
    localparam int LBL_W = 4;
    localparam int LAT   = N_IN / CHUNK + N_HID + N_OUT + 1;

    logic                         clk = 1'b0;
    logic                         reset;
    logic [N_HID*N_IN*WIDTH-1:0]  w1;
    logic [N_OUT*N_HID*WIDTH-1:0] w2;
    logic [N_IN-1:0]              in_data;
    logic                         in_valid;
    logic                         in_last;
    logic                         in_ready;
    logic                         out_valid;
    logic                         out_ready;
    logic [LBL_W-1:0]             out_label;
    logic                         out_last;
    logic [2:0]                   dbg_state;
`ifdef MLP_SAT_FLAG_EN
    logic                         out_sat;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int rdy_mode = 0;
    int cyc = 0;
    int t_acc = 0;
    bit pend = 0;
    logic [LBL_W:0] exp_q[$];
    longint m_h[N_HID];
    longint m_score[N_OUT];

    always #5 clk = ~clk;

    mlp_seq_engine dut (
        .clk       (clk),
        .reset     (reset),
        .w1        (w1),
        .w2        (w2),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_label (out_label),
        .out_last  (out_last),
`ifdef MLP_SAT_FLAG_EN
        .out_sat   (out_sat),
`endif
        .dbg_state (dbg_state)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint clamp(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: straight arithmetic over the whole vector in ascending order.
    function automatic int model_label(input logic [N_IN-1:0] d);
        longint acc, wv, p, q;
        int best;
        for (int i = 0; i < N_HID; i++) begin
            acc = 0;
            for (int j = 0; j < N_IN; j++)
                if (d[j]) begin
                    wv  = $signed(w1[(i*N_IN+j)*WIDTH +: WIDTH]);
                    acc = clamp(acc + wv);
                end
            m_h[i] = (acc < 0) ? 0 : acc;
        end
        for (int k = 0; k < N_OUT; k++) begin
            acc = 0;
            for (int i = 0; i < N_HID; i++) begin
                wv  = $signed(w2[(k*N_HID+i)*WIDTH +: WIDTH]);
                p   = wv * m_h[i];
                q   = clamp(p / (64'sd1 <<< FRAC));
                acc = clamp(acc + q);
            end
            m_score[k] = acc;
        end
        best = 0;
        for (int k = 1; k < N_OUT; k++)
            if (m_score[k] > m_score[best]) best = k;
        return best;
    endfunction

    // Compare process: checks the outputs every cycle against the transaction-level expectation.
    always @(negedge clk) begin
        bit exp_valid;
        logic [LBL_W:0] e;
        cyc++;
        if (reset) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_label", out_label, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_state", dbg_state, IDLE);
            pend = 0;
            exp_q.delete();
        end else begin
            exp_valid = pend && (cyc - t_acc >= LAT);
            chk("in_ready", in_ready, pend ? 0 : 1);
            chk("out_valid", out_valid, exp_valid);
            if (exp_valid && out_valid && exp_q.size() > 0) begin
                e = exp_q[0];
                chk("out_label", out_label, e[LBL_W-1:0]);
                chk("out_last", out_last, e[LBL_W]);
                chk("done_state", dbg_state, DONE);
            end
            if (in_valid && !pend) begin
                pend  = 1;
                t_acc = cyc;
                exp_q.push_back({in_last, LBL_W'(model_label(in_data))});
            end else if (exp_valid && out_ready) begin
                pend = 0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send(input logic [N_IN-1:0] d, input bit last);
        int  n;
        bit  acc;
        n   = 0;
        acc = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 300);
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (pend && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", pend, 0);
    endtask

    task automatic set_w1(input int i, input int j, input logic [WIDTH-1:0] v);
        w1[(i*N_IN+j)*WIDTH +: WIDTH] = v;
    endtask

    task automatic set_w2(input int k, input int i, input logic [WIDTH-1:0] v);
        w2[(k*N_HID+i)*WIDTH +: WIDTH] = v;
    endtask

    task automatic rand_weights(input bit full);
        for (int i = 0; i < N_HID; i++)
            for (int j = 0; j < N_IN; j++)
                set_w1(i, j, full ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512);
        for (int k = 0; k < N_OUT; k++)
            for (int i = 0; i < N_HID; i++)
                set_w2(k, i, full ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024);
    endtask

    function automatic logic [N_IN-1:0] rand_data(input int dens);
        logic [N_IN-1:0] d;
        for (int j = 0; j < N_IN; j++) d[j] = ($urandom_range(0, 99) < dens);
        return d;
    endfunction

    initial begin
        logic [N_IN-1:0] d;
        int lbl;
        int n;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        w1       = '0;
        w2       = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // All-zero input: every score is zero, label 0.
        rand_weights(1);
        d   = '0;
        lbl = model_label(d);
        chk("t1_model_label", lbl, 0);
        chk("t1_model_score9", m_score[9], 0);
        send(d, 0);
        wait_idle();

        // Single active pixel routed to class 7.
        w1 = '0;
        w2 = '0;
        set_w1(3, 0, 16'h0100);
        set_w2(7, 3, 16'h0100);
        d    = '0;
        d[0] = 1'b1;
        lbl  = model_label(d);
        chk("t2_model_h3", m_h[3], 256);
        chk("t2_model_score7", m_score[7], 256);
        chk("t2_model_label", lbl, 7);
        send(d, 0);
        wait_idle();

        // Hidden saturation without wrap.
        w1 = {(N_HID*N_IN){16'h7000}};
        w2 = '0;
        set_w2(4, 0, 16'h0100);
        d   = '1;
        lbl = model_label(d);
        chk("t3a_model_h0", m_h[0], 32767);
        chk("t3a_model_label", lbl, 4);
        send(d, 0);
        wait_idle();

        // Negative hidden sums are cut to zero by ReLU.
        w1 = {(N_HID*N_IN){16'h9000}};
        w2 = '0;
        set_w2(6, 0, 16'hFF00);
        lbl = model_label(d);
        chk("t3b_model_h0", m_h[0], 0);
        chk("t3b_model_label", lbl, 0);
        send(d, 0);
        wait_idle();

        // Tie between classes 5 and 9 resolves to 5.
        w1 = '0;
        w2 = '0;
        set_w1(0, 0, 16'h0100);
        set_w2(5, 0, 16'h0200);
        set_w2(9, 0, 16'h0200);
        d    = '0;
        d[0] = 1'b1;
        lbl  = model_label(d);
        chk("t4a_model_score5", m_score[5], 512);
        chk("t4a_model_label", lbl, 5);
        send(d, 0);
        wait_idle();

        // All scores negative, class 2 at -1 is the largest.
        for (int k = 0; k < N_OUT; k++) set_w2(k, 0, 16'hFD00);
        set_w2(2, 0, 16'hFFFF);
        lbl = model_label(d);
        chk("t4b_model_score2", m_score[2], -1);
        chk("t4b_model_label", lbl, 2);
        send(d, 0);
        wait_idle();

        // Fractional products truncate toward zero: -0.5 -> 0, so all scores tie at 0.
        set_w1(0, 0, 16'h0080);
        for (int k = 0; k < N_OUT; k++) set_w2(k, 0, 16'hFFFF);
        set_w2(8, 0, 16'h0001);
        lbl = model_label(d);
        chk("t4c_model_score0", m_score[0], 0);
        chk("t4c_model_label", lbl, 0);
        send(d, 0);
        wait_idle();

        // Back-pressure in DONE with in_last set; a second frame waits behind it.
        rand_weights(0);
        rdy_mode = 1;
        send(rand_data(50), 1);
        fork
            send(rand_data(30), 0);
            begin
                n = 0;
                while (!out_valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                chk("t5_valid_seen", out_valid, 1);
                repeat (20) @(negedge clk);
                @(posedge clk);
                #1;
                rdy_mode = 0;
            end
        join
        wait_idle();

        // Reset in the middle of L2 drops the frame; the next frame is reported normally.
        send(rand_data(50), 1);
        repeat (22) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        send(rand_data(40), 0);
        wait_idle();

        // Randomized batches with random sink stalls.
        for (int b = 0; b < 4; b++) begin
            rand_weights(b[0]);
            rdy_mode = (b < 2) ? 2 : 0;
            for (int f = 0; f < 4; f++)
                send(rand_data($urandom_range(5, 95)), 1'($urandom_range(0, 1)));
            wait_idle();
            rdy_mode = 0;
        end

        repeat (3) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
